// File: rtl/bit_counter_pkg.sv
// Shared width helpers and the tag payload that travels alongside each word in the counter pipeline.
package bit_counter_pkg;

    localparam int unsigned TAG_ID_W = 8;

    function automatic int unsigned cnt_w(input int unsigned width);
        return 32'($clog2(width)) + 32'd1;
    endfunction

    function automatic int unsigned id_w(input int unsigned n);
        return 32'($clog2(n));
    endfunction

    typedef struct packed {
        logic                val;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/bit_counter_rr_arb.sv
// Round-robin arbiter: one-hot and binary grant, pointer moves past the last winner.
module bit_counter_rr_arb
    import bit_counter_pkg::*;
#(
    parameter int unsigned REQ_NUM = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [REQ_NUM-1:0]         req_i,
    output logic [REQ_NUM-1:0]         gnt_oh_o,
    output logic [id_w(REQ_NUM)-1:0]   gnt_id_o
);

    localparam int unsigned ID_W = id_w(REQ_NUM);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] idx;
    logic            found;

    // Search from the pointer, wrapping modulo REQ_NUM; first hit wins.
    always_comb begin
        gnt_oh_o = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            idx = ID_W'((32'(ptr_q) + i) % REQ_NUM);
            if (en_i && !found && req_i[idx]) begin
                found         = 1'b1;
                gnt_oh_o[idx] = 1'b1;
                gnt_id_o      = idx;
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (32'(gnt_id_o) == REQ_NUM - 1) ? '0 : gnt_id_o + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bit_counter_arbiter.sv
// Shares one fixed-latency popcount pipeline among REQ_NUM requesters; a tag pipe
// carries each requester ID alongside its word so results return to the sender.
module bit_counter_arbiter
    import bit_counter_pkg::*;
#(
    parameter int unsigned REQ_NUM = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [REQ_NUM-1:0]             req_val_i,
    input  logic [REQ_NUM-1:0][WIDTH-1:0]  req_data_i,
    output logic [REQ_NUM-1:0]             req_ready_o,
    output logic [WIDTH-1:0]               cnt_data_o,
    output logic                           cnt_data_val_o,
    input  logic [cnt_w(WIDTH)-1:0]        cnt_count_i,
    input  logic                           cnt_count_val_i,
    output logic [REQ_NUM-1:0]             resp_val_o,
    output logic [id_w(REQ_NUM)-1:0]       resp_id_o,
    output logic [cnt_w(WIDTH)-1:0]        resp_count_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int unsigned CNT_W = cnt_w(WIDTH);
    localparam int unsigned ID_W  = id_w(REQ_NUM);
    localparam int unsigned DR_W  = $clog2(LATENCY + 2);
    localparam logic [DR_W-1:0] DRAIN_INIT = DR_W'(LATENCY + 1);

    logic [DR_W-1:0]    drain_q, drain_d;
    logic               issue_val_q, issue_val_d;
    logic [ID_W-1:0]    issue_id_q, issue_id_d;
    logic [WIDTH-1:0]   data_q, data_d;
    tag_t               tag_q [LATENCY];
    tag_t               tag_d [LATENCY];
    logic [REQ_NUM-1:0] resp_val_q, resp_val_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [CNT_W-1:0]   resp_count_q, resp_count_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               drain_done;
    logic [REQ_NUM-1:0] gnt_oh;
    logic [ID_W-1:0]    gnt_id;
    tag_t               tag_out;
    logic [ID_W-1:0]    tag_id;
    logic               hit;
    logic               mismatch;

    assign drain_done = (drain_q == '0);

    bit_counter_rr_arb #(
        .REQ_NUM (REQ_NUM)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (drain_done),
        .req_i    (req_val_i),
        .gnt_oh_o (gnt_oh),
        .gnt_id_o (gnt_id)
    );

    assign tag_out  = tag_q[LATENCY-1];
    assign tag_id   = ID_W'(tag_out.id);
    // Counter results are untrusted until the drain window has flushed stale words.
    assign hit      = drain_done && cnt_count_val_i && tag_out.val;
    assign mismatch = drain_done && (cnt_count_val_i != tag_out.val);

    always_comb begin
        drain_d      = drain_q;
        issue_val_d  = |gnt_oh;
        issue_id_d   = issue_id_q;
        data_d       = data_q;
        resp_val_d   = '0;
        resp_id_d    = resp_id_q;
        resp_count_d = resp_count_q;
        err_d        = err_q | mismatch;

        if (!drain_done) begin
            drain_d = drain_q - DR_W'(1);
        end

        if (issue_val_d) begin
            issue_id_d = gnt_id;
            data_d     = req_data_i[gnt_id];
        end

        tag_d[0] = '{val: issue_val_q, id: TAG_ID_W'(issue_id_q)};
        for (int i = 1; i < int'(LATENCY); i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (hit) begin
            resp_val_d   = REQ_NUM'(1) << tag_id;
            resp_id_d    = tag_id;
            resp_count_d = cnt_count_i;
        end

        // Busy mirrors the next-cycle contents of the issue register and tag pipe.
        busy_d = issue_val_d | issue_val_q;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            busy_d = busy_d | tag_q[i].val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drain_q      <= DRAIN_INIT;
            issue_val_q  <= 1'b0;
            issue_id_q   <= '0;
            data_q       <= '0;
            resp_val_q   <= '0;
            resp_id_q    <= '0;
            resp_count_q <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            drain_q      <= drain_d;
            issue_val_q  <= issue_val_d;
            issue_id_q   <= issue_id_d;
            data_q       <= data_d;
            resp_val_q   <= resp_val_d;
            resp_id_q    <= resp_id_d;
            resp_count_q <= resp_count_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            for (int i = 0; i < int'(LATENCY); i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign req_ready_o    = gnt_oh;
    assign cnt_data_o     = data_q;
    assign cnt_data_val_o = issue_val_q;
    assign resp_val_o     = resp_val_q;
    assign resp_id_o      = resp_id_q;
    assign resp_count_o   = resp_count_q;
    assign busy_o         = busy_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_bit_counter_arbiter.sv
// Directed bench for bit_counter_arbiter with an unreset 4-stage popcount pipeline as the shared counter.
module tb_bit_counter_arbiter;

    localparam int unsigned REQ_NUM = 4;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned ID_W    = 2;

    logic                          clk_i = 1'b0;
    logic                          rst_ni;
    logic [REQ_NUM-1:0]            req_val_i;
    logic [REQ_NUM-1:0][WIDTH-1:0] req_data_i;
    logic [REQ_NUM-1:0]            req_ready_o;
    logic [WIDTH-1:0]              cnt_data_o;
    logic                          cnt_data_val_o;
    logic [CNT_W-1:0]              cnt_count_i;
    logic                          cnt_count_val_i;
    logic [REQ_NUM-1:0]            resp_val_o;
    logic [ID_W-1:0]               resp_id_o;
    logic [CNT_W-1:0]              resp_count_o;
    logic                          busy_o;
    logic                          err_o;

    logic                          inject;
    bit   [LATENCY-1:0]            pv;
    bit   [CNT_W-1:0]              pc [LATENCY];

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    bit_counter_arbiter #(
        .REQ_NUM (REQ_NUM),
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_val_i       (req_val_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .cnt_data_o      (cnt_data_o),
        .cnt_data_val_o  (cnt_data_val_o),
        .cnt_count_i     (cnt_count_i),
        .cnt_count_val_i (cnt_count_val_i),
        .resp_val_o      (resp_val_o),
        .resp_id_o       (resp_id_o),
        .resp_count_o    (resp_count_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    // External counter: not reset, so it can deliver stale results after a DUT reset.
    always @(posedge clk_i) begin
        pv    <= {pv[LATENCY-2:0], cnt_data_val_o};
        pc[0] <= CNT_W'($countones(cnt_data_o));
        for (int i = 1; i < int'(LATENCY); i++) pc[i] <= pc[i-1];
    end
    assign cnt_count_val_i = pv[LATENCY-1] | inject;
    assign cnt_count_i     = pc[LATENCY-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 40) begin
            cyc();
            #1;
            n++;
        end
        chk(tag, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g [5];
        int         j;
        g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_ni     = 1'b0;
        req_val_i  = '0;
        req_data_i = '0;
        inject     = 1'b0;
        repeat (6) @(posedge clk_i);
        #3;
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_cval", 32'(cnt_data_val_o), 32'd0);
        chk("rst_cdata", 32'(cnt_data_o), 32'd0);
        chk("rst_rval", 32'(resp_val_o), 32'd0);
        chk("rst_rid", 32'(resp_id_o), 32'd0);
        chk("rst_rcnt", 32'(resp_count_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);

        // Drain window then round-robin over all four requesters
        @(posedge clk_i);
        #2;
        rst_ni     = 1'b1;
        req_val_i  = 4'b1111;
        req_data_i = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
        #1;
        chk("drain_ready", 32'(req_ready_o), 32'd0);
        for (int k = 1; k < 5; k++) begin
            cyc(); #1;
            chk("drain_ready", 32'(req_ready_o), 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            chk("rr_grant", 32'(req_ready_o), 32'(g[k]));
        end
        cyc();
        req_val_i = '0;
        #1;
        wait_idle("idle_rr");
        chk("err_rr", 32'(err_o), 32'd0);

        // Single FFFF from requester 2: six cycles accept to response
        cyc();
        req_val_i     = 4'b0100;
        req_data_i[2] = 16'hFFFF;
        #1;
        chk("ff_grant", 32'(req_ready_o), 32'b0100);
        cyc();
        req_val_i = '0;
        #1;
        chk("ff_cval", 32'(cnt_data_val_o), 32'd1);
        chk("ff_cdata", 32'(cnt_data_o), 32'hFFFF);
        chk("ff_busy", 32'(busy_o), 32'd1);
        chk("ff_early", 32'(resp_val_o), 32'd0);
        for (int k = 2; k < 6; k++) begin
            cyc(); #1;
            chk("ff_early", 32'(resp_val_o), 32'd0);
        end
        cyc(); #1;
        chk("ff_rval", 32'(resp_val_o), 32'b0100);
        chk("ff_rid", 32'(resp_id_o), 32'd2);
        chk("ff_rcnt", 32'(resp_count_o), 32'd16);
        cyc(); #1;
        chk("ff_rval_off", 32'(resp_val_o), 32'd0);
        chk("ff_rcnt_hold", 32'(resp_count_o), 32'd16);

        // Requesters 0 and 3 stream back-to-back
        cyc();
        req_val_i     = 4'b1001;
        req_data_i[0] = 16'h0000;
        req_data_i[3] = 16'h8001;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) cyc();
            if (k == 6) req_val_i = '0;
            #1;
            if (k < 6) begin
                chk("st_grant", 32'(req_ready_o), (k % 2 == 0) ? 32'b1000 : 32'b0001);
            end else begin
                j = k - 6;
                chk("st_rval", 32'(resp_val_o), (j % 2 == 0) ? 32'b1000 : 32'b0001);
                chk("st_rid", 32'(resp_id_o), (j % 2 == 0) ? 32'd3 : 32'd0);
                chk("st_rcnt", 32'(resp_count_o), (j % 2 == 0) ? 32'd2 : 32'd0);
            end
        end
        cyc(); #1;
        chk("st_rval_off", 32'(resp_val_o), 32'd0);

        // Spurious count valid with nothing in flight
        wait_idle("idle_st");
        chk("err_pre", 32'(err_o), 32'd0);
        cyc();
        inject = 1'b1;
        cyc();
        inject = 1'b0;
        #1;
        chk("err_set", 32'(err_o), 32'd1);
        chk("err_rval", 32'(resp_val_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("err_hold", 32'(err_o), 32'd1);
        end

        // Reset with three words in flight
        cyc();
        req_val_i = 4'b0111;
        #1;
        chk("fl_grant", 32'(req_ready_o), 32'b0010);
        cyc(); #1;
        chk("fl_grant", 32'(req_ready_o), 32'b0100);
        cyc(); #1;
        chk("fl_grant", 32'(req_ready_o), 32'b0001);
        cyc();
        req_val_i = '0;
        #1;
        cyc();
        rst_ni = 1'b0;
        #1;
        chk("fl_busy", 32'(busy_o), 32'd0);
        chk("fl_rval", 32'(resp_val_o), 32'd0);
        chk("fl_err", 32'(err_o), 32'd0);
        chk("fl_cval", 32'(cnt_data_val_o), 32'd0);
        cyc();
        rst_ni = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("stale_rval", 32'(resp_val_o), 32'd0);
            chk("stale_err", 32'(err_o), 32'd0);
            cyc(); #1;
        end

        // Lone requester 1 granted every cycle, then pointer check
        req_val_i     = 4'b0010;
        req_data_i[1] = 16'h00F0;
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("solo_grant", 32'(req_ready_o), 32'b0010);
            if (k >= 6) begin
                chk("solo_rval", 32'(resp_val_o), 32'b0010);
                chk("solo_rcnt", 32'(resp_count_o), 32'd4);
            end
            cyc(); #1;
        end
        req_val_i = 4'b0110;
        #1;
        chk("ptr_grant", 32'(req_ready_o), 32'b0100);
        cyc(); #1;
        chk("ptr_next", 32'(req_ready_o), 32'b0010);
        cyc();
        req_val_i = '0;
        #1;
        wait_idle("idle_end");
        chk("err_end", 32'(err_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_counter_arbiter.md
Name: bit_counter_arbiter

Overview:
Shares one fixed-latency pipelined population counter between REQ_NUM requesters. Round-robin arbitration picks one request per cycle and issues it to the counter. A tag shift register tracks the requester ID alongside each word, so each result returns to the requester that sent it. The block sits between requester-side valid/ready ports and the counter's valid-only interface, which has no backpressure.

Parameters:
REQ_NUM, 4, number of requesters (>=2)
WIDTH, 16, data word width; count width is $clog2(WIDTH)+1
LATENCY, 4, cycles from cnt_data_val_o to the matching cnt_count_val_i (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_val_i  in  REQ_NUM  per-requester request valid
req_data_i  in  REQ_NUM x WIDTH  per-requester data word
req_ready_o  out  REQ_NUM  one-hot grant (accept) this cycle
cnt_data_o  out  WIDTH  word to counter
cnt_data_val_o  out  1  word valid to counter
cnt_count_i  in  $clog2(WIDTH)+1  count from counter
cnt_count_val_i  in  1  count valid from counter
resp_val_o  out  REQ_NUM  one-hot result strobe
resp_id_o  out  $clog2(REQ_NUM)  requester ID of current result
resp_count_o  out  $clog2(WIDTH)+1  popcount result
busy_o  out  1  any word issued or in flight
err_o  out  1  sticky tag/valid mismatch flag

Behaviour:
- Reset (rst_ni low, async): all outputs 0; rr pointer 0; tag pipe cleared; drain counter loaded with LATENCY+1.
- Drain: while drain counter != 0 it decrements each cycle, req_ready_o is forced to 0, and cnt_count_val_i is ignored (stale results from a counter that was not reset). The drain also applies to a reset asserted mid-operation; in-flight words are discarded and produce no response.
- Arbitration, combinational: search starts at the pointer and wraps modulo REQ_NUM. The first k with req_val_i[k] high gets req_ready_o[k] = 1, at most one bit. Ready depends on valid; a requester must not make valid depend on ready.
- Pointer: on a grant to k, the pointer becomes (k+1) mod REQ_NUM. With no grant it holds. A single continuous requester is granted every cycle.
- Issue, registered: on the cycle after an accept, cnt_data_o = the accepted word, cnt_data_val_o = 1, and tag_in = {1, k}. With no accept, cnt_data_val_o = 0 and cnt_data_o holds its previous value.
- Tag pipe: LATENCY stages of {valid, id}, shifting every cycle in step with cnt_data_val_o. Stage LATENCY-1 is aligned with cnt_count_val_i.
- Response, registered: when cnt_count_val_i and the tag valid are both high, resp_val_o = onehot(id), resp_id_o = id, resp_count_o = cnt_count_i. Otherwise resp_val_o = 0 and the data outputs hold.
- Total latency from accept edge to resp_val_o = LATENCY+2 cycles. Throughput is one result per cycle.
- err_o: set when the tag valid differs from cnt_count_val_i outside the drain window. It stays set until reset. The mismatched cycle produces no response.
- busy_o: OR of the issue register valid and all tag valid bits.
- Simultaneous grant and response for the same requester is legal; the two paths are independent.

Decomposition:
- Package bit_counter_pkg holds functions cnt_w(WIDTH) = $clog2(WIDTH)+1 and id_w(REQ_NUM) = $clog2(REQ_NUM), plus the tag_t struct {logic val; id}.
- Sub-module bit_counter_rr_arb (parameter REQ_NUM) holds the round-robin pointer and produces the one-hot and binary grant.

Test Plan:
- After reset release, req_val_i = 4'b1111 -> req_ready_o stays 0 for 5 cycles, then grants 0,1,2,3,0 on consecutive cycles.
- Requester 2 sends 16'hFFFF -> resp_val_o = 4'b0100, resp_id_o = 2, resp_count_o = 16, exactly 6 cycles after accept.
- Requesters 0 and 3 stream 16'h0000 and 16'h8001 back-to-back -> results alternate 0 and 2 with the correct IDs, with no gaps.
- Inject cnt_count_val_i = 1 while no word is in flight, after the drain -> err_o = 1 and resp_val_o stays 0; err_o holds until reset.
- Assert rst_ni low while 3 words are in flight -> no response for those words, busy_o = 0, and a stale cnt_count_val_i arriving within 5 cycles of reset release is ignored with err_o = 0.
- Only requester 1 is valid for 10 cycles -> granted every cycle; the pointer reaches 2, so a simultaneous request from 1 and 2 next grants 2.
